// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_idx_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_nbit_clk_gen.sv
// Half-period divider producing spi_clk and one-cycle leading/trailing edge strobes.
module spi_clk_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic edge_en,
    input  logic cpol,
    output logic spi_clk,
    output logic lead_stb,
    output logic trail_stb,
    output logic half_end
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    // Strobes are high in the cycle before spi_clk toggles; consumers act on the same edge.
    assign half_end  = run && (cnt == LAST);
    assign lead_stb  = half_end && edge_en && (spi_clk == cpol);
    assign trail_stb = half_end && edge_en && (spi_clk != cpol);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            spi_clk <= cpol;
        end else begin
            cnt <= half_end ? '0 : cnt + 1'b1;
            if (half_end && edge_en) spi_clk <= ~spi_clk;
        end
    end

endmodule

// File: rtl/spi_master_nbit.sv
// Full-duplex SPI master: configurable width, divider, chip selects and CPOL/CPHA.
module spi_master_nbit
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    localparam int CSW    = cs_idx_w(NUM_CS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int H  = CLK_DIV / 2;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_EDGE = BW'(2 * DATA_W - 1);
    localparam logic [CSW:0]  NUM_CS_V  = (CSW + 1)'(NUM_CS);

    spi_state_t        state, state_nxt;
    logic [1:0]        mode_q;
    logic              cpol_q, cpha_q, cpol_src;
    logic [CSW-1:0]    cs_q, cs_idx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     edge_cnt;
    logic              run, edge_en, half_end, lead_stb, trail_stb;
    logic              cs_ok, accept, last_edge, busy_nxt;

    assign cpol_q    = (mode_q == MODE2) || (mode_q == MODE3);
    assign cpha_q    = (mode_q == MODE1) || (mode_q == MODE3);
    assign cs_ok     = ({1'b0, cs_sel} < NUM_CS_V);
    assign accept    = (state == ST_IDLE) && start && cs_ok;
    assign last_edge = (edge_cnt == LAST_EDGE);
    assign cpol_src  = (state == ST_IDLE) ? cpol : cpol_q;
    assign cs_idx    = (state == ST_IDLE) ? cs_sel : cs_q;
    assign busy_nxt  = (state_nxt == ST_SETUP) || (state_nxt == ST_XFER) || (state_nxt == ST_HOLD);

    spi_clk_gen #(.HALF(H)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .edge_en   (edge_en),
        .cpol      (cpol_src),
        .spi_clk   (spi_clk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .half_end  (half_end)
    );

    // SETUP is the first half-period; its end is the first spi_clk edge.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        edge_en   = 1'b0;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            ST_SETUP: begin
                run = 1'b1; edge_en = 1'b1;
                if (half_end) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                run = 1'b1; edge_en = 1'b1;
                if (half_end && last_edge) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                run = 1'b1;
                if (half_end) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake: start is taken only in IDLE with a valid cs_sel; done pulses one cycle
    // after the word is complete, and busy covers every cycle a chip select is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE0;
            cs_q     <= '0;
            shreg    <= '0;
            edge_cnt <= '0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            cs_n     <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= (state_nxt == ST_DONE);
            cs_n  <= busy_nxt ? ~(NUM_CS'(1) << cs_idx) : '1;
            if (accept) begin
                mode_q   <= {cpol, cpha};
                cs_q     <= cs_sel;
                shreg    <= tx_data;
                edge_cnt <= '0;
                if (!cpha) mosi <= tx_data[DATA_W-1];
            end else begin
                if (lead_stb) begin
                    if (!cpha_q) begin
                        shreg <= {shreg[DATA_W-2:0], miso};
                    end else begin
                        mosi  <= shreg[DATA_W-1];
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
                    end
                end
                // The final trailing edge leaves mosi on the last data bit through HOLD.
                if (trail_stb) begin
                    if (!cpha_q) begin
                        if (!last_edge) mosi <= shreg[DATA_W-1];
                    end else begin
                        shreg[0] <= miso;
                    end
                end
                if ((lead_stb || trail_stb) && !last_edge) edge_cnt <= edge_cnt + 1'b1;
                if ((state == ST_HOLD) && half_end) rx_data <= shreg;
            end
        end
    end

endmodule
